// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver.
//
// The asynchronous rx line is synchronised. A falling edge is confirmed at the
// middle of the start bit, and each data bit is then sampled at its centre, LSB
// first. The stop bit is checked last. A good frame updates rx_data_o and pulses
// rx_valid_o for one clk. A low stop bit pulses frame_err_o instead, and the
// receiver then waits for the line to return high before it accepts another frame.
//
// Optional feature: define UART_RX_PARITY_EN to insert a parity bit between the
// data bits and the stop bit. The parity sense is set by PARITY_ODD. When the
// macro is undefined, parity_err_o is tied low.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   baud_tick_i  single-clk pulse at SMP_RATE x baud rate
//   rx_i         asynchronous serial line, idle high
//   rx_data_o    last received word, LSB = first bit on the wire
//   rx_valid_o   one-clk pulse: rx_data_o updated
//   frame_err_o  one-clk pulse: stop bit sampled low
//   parity_err_o one-clk pulse: parity mismatch (alongside rx_valid_o)
module uart_rx_os #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned SMP_RATE   = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o
);

    localparam int unsigned TickW = $clog2(SMP_RATE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [TickW-1:0] TickMid  = TickW'(SMP_RATE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(SMP_RATE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    logic                 rx_meta_q, rx_s_q;
    state_e               state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;

`ifdef UART_RX_PARITY_EN
    localparam logic ParOdd = (PARITY_ODD != 0);
    logic parity_q, parity_d;
    logic parity_err_q, parity_err_d;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = ^PARITY_ODD;
`endif

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d     = parity_q;
        parity_err_d = 1'b0;
`endif
        if (baud_tick_i) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        tick_cnt_d = '0;
                        state_d    = StStart;
                    end
                end
                StStart: begin
                    if (tick_cnt_q == TickMid) begin
                        if (!rx_s_q) begin
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = StData;
                        end else begin
                            // Start bit gone high by mid-bit: treat as a glitch.
                            state_d = StIdle;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StData: begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + BitW'(1);
                        if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        parity_d   = rx_s_q;
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
`endif
                StStop: begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = (parity_q != ((^shift_q) ^ ParOdd));
`endif
                            state_d = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StWaitHigh;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StWaitHigh: begin
                    // A held-low line (break) must not be decoded as frames.
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os (DATA_BITS=8, SMP_RATE=16, even parity).
module tb_uart_rx_os;

    localparam int SMP = 16;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    localparam logic PAR_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err;

    uart_rx_os #(
        .DATA_BITS (8),
        .SMP_RATE  (SMP),
        .PARITY_ODD(0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick_i (baud_tick),
        .rx_i        (rx),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .frame_err_o (frame_err),
        .parity_err_o(parity_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic tick_en = 1'b1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // baud_tick every 4 clks, changed on negedge so it is stable at posedge.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            baud_tick = tick_en && (div == 0);
        end
    end

    // Event monitor, sampling on the falling edge.
    logic [8:0] got_q[$];
    int         ferr_cnt = 0;
    int         perr_orphan = 0;
    int         wide_cnt = 0;
    int         valid_cyc = 0;
    int         edge_cyc = 0;
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rx_valid) begin
                    got_q.push_back({parity_err, rx_data});
                    valid_cyc = cyc;
                    if (prev_valid) wide_cnt++;
                end
                if (frame_err) ferr_cnt++;
                if (parity_err && !rx_valid) perr_orphan++;
            end
            prev_valid = rx_valid;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish in 90000 clks");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(SMP);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip,
                              input int gap);
        wait_ticks(gap);
        @(negedge clk);
        rx = 1'b0;
        edge_cyc = cyc;
        wait_ticks(SMP);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit((^d) ^ PAR_ODD ^ flip);
        send_bit(stop);
        @(negedge clk);
        rx = 1'b1;
    endtask

    // Reference: last word delivered by a good frame.
    logic [7:0] last_good = 8'h00;

    task automatic check_frame(input string name, input logic exp_valid, input logic [7:0] exp_d,
                               input logic exp_ferr, input logic exp_perr);
        logic [8:0] ev;
        check({name, " valid count"}, got_q.size(), exp_valid ? 1 : 0);
        if (exp_valid && got_q.size() > 0) begin
            ev = got_q.pop_front();
            check({name, " data"}, ev[7:0], exp_d);
            check({name, " parity_err"}, ev[8], exp_perr);
            last_good = exp_d;
        end
        check({name, " frame_err count"}, ferr_cnt, exp_ferr ? 1 : 0);
        check({name, " rx_data hold"}, rx_data, last_good);
        got_q.delete();
        ferr_cnt = 0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       flip;
        int         gap;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    initial begin
        vec_t       vecs[7];
        logic [7:0] d;
        logic       s, f;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};  // back-to-back
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0};  // bad stop bit
        vecs[4] = '{8'h5A, 1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 4, 1'b1, 1'b0, PAR_EN};

        // Reset values
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset parity_err", parity_err, 1'b0);
        rst = 1'b0;

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].flip, vecs[i].gap);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].data,
                        vecs[i].exp_ferr, vecs[i].exp_perr);
        end

        // Latency: stop sampled ~9.5 bit periods (608 clks) after the start edge.
        send_frame(8'hC3, 1'b1, 1'b0, 6);
        check("latency window", ((valid_cyc - edge_cyc) >= 600) && ((valid_cyc - edge_cyc) <= 624),
              1'b1);
        check_frame("latency frame", 1'b1, 8'hC3, 1'b0, 1'b0);

        // Glitch: 4 ticks low, then idle; a following frame proves the FSM is idle.
        wait_ticks(4);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(24);
        check_frame("glitch", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0, 2);
        check_frame("after glitch", 1'b1, 8'h33, 1'b0, 1'b0);

        // Reset during data bit 4 of 0x81
        wait_ticks(4);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(SMP);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(SMP / 2);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("mid-frame reset rx_data", rx_data, 8'h00);
        check("mid-frame reset rx_valid", rx_valid, 1'b0);
        last_good = 8'h00;
        wait_ticks(30);
        check_frame("abandoned 0x81", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b0, 2);
        check_frame("after reset", 1'b1, 8'h7E, 1'b0, 1'b0);

        // baud_tick paused mid-frame: FSM freezes, frame still decodes.
        fork
            send_frame(8'h96, 1'b1, 1'b0, 4);
            begin
                repeat (300) @(negedge clk);
                tick_en = 1'b0;
                repeat (200) @(negedge clk);
                tick_en = 1'b1;
            end
        join
        check_frame("tick pause", 1'b1, 8'h96, 1'b0, 1'b0);

        // Break: line held low for 30 bit periods gives one frame error, no data.
        wait_ticks(4);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(SMP * 30);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(20);
        check_frame("break", 1'b0, 8'h00, 1'b1, 1'b0);

        // Random frames against the frame-level model
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            f = 1'($urandom);
            send_frame(d, s, f, $urandom_range(0, 6));
            if (!s) wait_ticks(4);
            check_frame($sformatf("rand%0d", i), s, d, !s, PAR_EN && s && f);
        end

        check("rx_valid pulse width", wide_cnt, 0);
        check("parity_err without rx_valid", perr_orphan, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
UART receiver for the serial link, the receive-side consumer of the 16x oversampling tick from the baud rate generator. It synchronises the asynchronous rx line, detects and validates the start bit at mid-bit, and samples each data bit at its centre, LSB first. It checks the stop bit and presents each received word as a single-cycle valid pulse. Frame errors are flagged separately.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
SMP_RATE, 16, baud_tick pulses per bit period; even, >=4; must match the generator's oversampling rate
PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd); ignored otherwise

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
baud_tick  input  1  single-clk pulse at SMP_RATE x baud rate
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last received word, LSB = first bit on the wire
rx_valid  output  1  one-clk pulse: rx_data updated
frame_err  output  1  one-clk pulse: stop bit sampled low
parity_err  output  1  one-clk pulse: parity mismatch (constant 0 when feature is off)

Behaviour:
- Clock, reset and interface: rst is synchronous, active-high; clk is the only clock. All state changes on posedge clk.
- rx passes through a 2-flop synchroniser (rx_s). The synchroniser flops reset to 1.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, state=IDLE, tick_cnt=0, bit_cnt=0.
- tick_cnt width is $clog2(SMP_RATE). bit_cnt width is $clog2(DATA_BITS+1).
- tick_cnt advances only on baud_tick. The FSM evaluates only on baud_tick clock cycles, except output pulses.
- IDLE:
  - On baud_tick with rx_s=0: tick_cnt=0, go to START.
- START:
  - On each baud_tick, tick_cnt++.
  - When tick_cnt reaches SMP_RATE/2-1 (mid start bit), sample rx_s.
  - rx_s=0: tick_cnt=0, bit_cnt=0, go to DATA.
  - rx_s=1: glitch; go to IDLE with no outputs.
- DATA:
  - On each baud_tick, tick_cnt++.
  - When tick_cnt=SMP_RATE-1: tick_cnt=0, shift rx_s into the MSB of the shift register (right shift), bit_cnt++.
  - After DATA_BITS samples, go to PARITY (feature on) or STOP.
- PARITY: same timing as one data bit. Stores the sampled parity bit.
- STOP: sample at tick_cnt=SMP_RATE-1.
  - rx_s=1: rx_data <= shift register, rx_valid=1 for exactly one clk; go to IDLE.
  - rx_s=0: frame_err=1 for one clk; rx_data unchanged, no rx_valid; go to WAIT_HIGH.
- WAIT_HIGH: stay until a baud_tick with rx_s=1, then go to IDLE. A held-low line (break) never produces frames.
- Latency: rx_valid asserts in the clk cycle after the baud_tick that samples the stop bit. This is about 9.5 bit periods after the start edge for 8N1.
- rx_data holds its value until the next valid frame.
- Output pulses are registered and deassert on the next clk regardless of baud_tick.
- baud_tick held low: the FSM freezes in its current state.
- rst mid-frame: abandon the frame and return to reset values next cycle. No partial rx_valid.
- Next frame: a start edge is accepted from the first baud_tick in IDLE after a good stop sample. Back-to-back frames with a single stop bit are supported.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - Expected parity = XOR of the data bits, inverted when PARITY_ODD=1.
  - On a good stop bit, rx_valid pulses. parity_err pulses in the same clk if the sampled parity bit differs from expected; rx_data is still updated.
  - On a bad stop bit, frame_err only.
- Undefined:
  - No PARITY state; the frame is start + DATA_BITS + stop.
  - parity_err is tied to 0.

Test Plan:
- Reset values: drive rst=1 for 3 clks with rx=1 -> all outputs 0.
- Basic frame: baud_tick every 4 clks, send 8N1 0xA5 at SMP_RATE ticks/bit -> one rx_valid pulse of width 1 clk, rx_data=0xA5, frame_err=0.
- Glitch and back-to-back:
  - rx low for 4 ticks then high -> no rx_valid; FSM back in IDLE.
  - Send 0x00 then 0xFF back-to-back -> two rx_valid pulses with 0x00, 0xFF.
- Frame error: send 0x3C with stop bit 0, then line high, then 0x5A -> frame_err pulse, rx_data stays 0xA5 (or its prior value), no rx_valid. Then rx_valid with rx_data=0x5A.
- Reset mid-frame: assert rst during data bit 4 of 0x81, release, send 0x7E -> no pulse for 0x81; rx_valid with rx_data=0x7E.
- Parity (UART_RX_PARITY_EN, PARITY_ODD=0):
  - Send 0x81 with parity bit 0 -> rx_valid, parity_err=0.
  - Send 0x81 with parity bit 1 -> rx_valid and parity_err in the same clk, rx_data=0x81.
